bsg_cache_nb_dma_splitter: RTL and testbench



---
 rtl/bsg_cache_nb_dma_splitter.sv | 181 ++++++++++++++++++
 tb/tb_bsg_cache_nb_dma_splitter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_nb_dma_splitter.sv
// Splits the bsg_cache_nb DMA packet stream into read requests and queued evictions, and buffers refill beats.
// Optional BSG_CACHE_NB_DMA_SPLITTER_RAW_CHECK_EN: reads stall only on a block-address match instead of on any pending evict.
module bsg_cache_nb_dma_splitter #(
    parameter int addr_width_p          = 32,
    parameter int word_width_p          = 32,
    parameter int dma_data_width_p      = 64,
    parameter int block_size_in_words_p = 8,
    parameter int mshr_els_p            = 4,
    parameter int evict_els_p           = 4,
    parameter int bursts_lp             = block_size_in_words_p*word_width_p/dma_data_width_p,
    parameter int refill_els_p          = mshr_els_p*bursts_lp,
    localparam int lg_mshr_els_lp       = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1,
    // packet layout, MSB first: {write_not_read, addr, mask, mshr_id}
    localparam int dma_pkt_width_lp     = 1 + addr_width_p + block_size_in_words_p + lg_mshr_els_lp
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,

    input  logic [dma_data_width_p-1:0] dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o,

    output logic [dma_data_width_p-1:0] dma_data_o,
    output logic [lg_mshr_els_lp-1:0]   dma_mshr_id_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_i,

    output logic [dma_pkt_width_lp-1:0] rd_pkt_o,
    output logic                        rd_pkt_v_o,
    input  logic                        rd_pkt_yumi_i,

    output logic [dma_pkt_width_lp-1:0] wr_pkt_o,
    output logic                        wr_pkt_v_o,
    input  logic                        wr_pkt_yumi_i,

    output logic [dma_data_width_p-1:0] wr_data_o,
    output logic                        wr_data_v_o,
    input  logic                        wr_data_yumi_i,

    input  logic [dma_data_width_p-1:0] mem_data_i,
    input  logic [lg_mshr_els_lp-1:0]   mem_mshr_id_i,
    input  logic                        mem_data_v_i,
    output logic                        mem_data_ready_o
);

    localparam int lg_evict_lp  = $clog2(evict_els_p);
    localparam int lg_refill_lp = $clog2(refill_els_p);
    localparam int lg_bursts_lp = (bursts_lp > 1) ? $clog2(bursts_lp) : 1;

    typedef enum logic [1:0] {e_idle, e_hdr, e_data} state_e;

    state_e                  state_r, state_n;
    logic [lg_bursts_lp-1:0] cnt_r, cnt_n;

    logic [dma_pkt_width_lp-1:0] evict_q_r [evict_els_p];
    logic [lg_evict_lp:0]        ev_wptr_r, ev_rptr_r, ev_count;
    logic                        ev_full, ev_empty, ev_enq, ev_deq;
    logic                        pkt_is_write, hazard;

    assign pkt_is_write = dma_pkt_i[dma_pkt_width_lp-1];
    assign ev_empty = (ev_wptr_r == ev_rptr_r);
    assign ev_full  = (ev_wptr_r[lg_evict_lp] != ev_rptr_r[lg_evict_lp])
                    && (ev_wptr_r[lg_evict_lp-1:0] == ev_rptr_r[lg_evict_lp-1:0]);
    assign ev_count = ev_wptr_r - ev_rptr_r;
    // full is sampled before any same-cycle dequeue, so a full queue never accepts
    assign ev_enq   = ~reset & dma_pkt_v_i & pkt_is_write & ~ev_full;

`ifdef BSG_CACHE_NB_DMA_SPLITTER_RAW_CHECK_EN
    localparam int blk_offset_lp = $clog2(block_size_in_words_p) + $clog2(word_width_p/8);
    localparam int addr_lsb_lp   = lg_mshr_els_lp + block_size_in_words_p;

    logic [lg_evict_lp-1:0]  slot_off;
    logic [addr_width_p-1:0] rd_addr, slot_addr;

    assign rd_addr = dma_pkt_i[addr_lsb_lp +: addr_width_p];

    // a slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        hazard    = 1'b0;
        slot_off  = '0;
        slot_addr = '0;
        for (int i = 0; i < evict_els_p; i++) begin
            slot_off  = lg_evict_lp'(i) - ev_rptr_r[lg_evict_lp-1:0];
            slot_addr = evict_q_r[i][addr_lsb_lp +: addr_width_p];
            if (({1'b0, slot_off} < ev_count)
                && ((slot_addr >> blk_offset_lp) == (rd_addr >> blk_offset_lp)))
                hazard = 1'b1;
        end
    end
`else
    assign hazard = ~ev_empty;
`endif

    assign rd_pkt_o       = dma_pkt_i;
    assign rd_pkt_v_o     = ~reset & dma_pkt_v_i & ~pkt_is_write & ~hazard;
    assign dma_pkt_yumi_o = pkt_is_write ? ev_enq : (rd_pkt_v_o & rd_pkt_yumi_i);

    assign wr_pkt_o  = evict_q_r[ev_rptr_r[lg_evict_lp-1:0]];
    assign wr_data_o = dma_data_i;

    always_comb begin
        state_n         = state_r;
        cnt_n           = cnt_r;
        ev_deq          = 1'b0;
        wr_pkt_v_o      = 1'b0;
        wr_data_v_o     = 1'b0;
        dma_data_yumi_o = 1'b0;
        if (!reset) begin
            case (state_r)
                e_idle: if (!ev_empty) state_n = e_hdr;
                e_hdr: begin
                    wr_pkt_v_o = 1'b1;
                    if (wr_pkt_yumi_i) state_n = e_data;
                end
                e_data: begin
                    wr_data_v_o     = dma_data_v_i;
                    dma_data_yumi_o = dma_data_v_i & wr_data_yumi_i;
                    if (dma_data_yumi_o) begin
                        if (cnt_r == lg_bursts_lp'(bursts_lp-1)) begin
                            cnt_n   = '0;
                            ev_deq  = 1'b1;
                            state_n = (ev_count > (lg_evict_lp+1)'(1)) ? e_hdr : e_idle;
                        end else begin
                            cnt_n = cnt_r + 1'b1;
                        end
                    end
                end
                default: state_n = e_idle;
            endcase
        end
    end

    logic [dma_data_width_p-1:0] rf_data_r [refill_els_p];
    logic [lg_mshr_els_lp-1:0]   rf_id_r   [refill_els_p];
    logic [lg_refill_lp:0]       rf_wptr_r, rf_rptr_r;
    logic                        rf_full, rf_empty, rf_push, rf_pop;

    assign rf_empty = (rf_wptr_r == rf_rptr_r);
    assign rf_full  = (rf_wptr_r[lg_refill_lp] != rf_rptr_r[lg_refill_lp])
                    && (rf_wptr_r[lg_refill_lp-1:0] == rf_rptr_r[lg_refill_lp-1:0]);

    assign mem_data_ready_o = ~reset & ~rf_full;
    assign dma_data_v_o     = ~reset & ~rf_empty;
    assign rf_push          = mem_data_v_i & mem_data_ready_o;
    assign rf_pop           = dma_data_v_o & dma_data_ready_i;
    assign dma_data_o       = rf_data_r[rf_rptr_r[lg_refill_lp-1:0]];
    assign dma_mshr_id_o    = rf_id_r[rf_rptr_r[lg_refill_lp-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= e_idle;
            cnt_r     <= '0;
            ev_wptr_r <= '0;
            ev_rptr_r <= '0;
            rf_wptr_r <= '0;
            rf_rptr_r <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (ev_enq) ev_wptr_r <= ev_wptr_r + 1'b1;
            if (ev_deq) ev_rptr_r <= ev_rptr_r + 1'b1;
            if (rf_push) rf_wptr_r <= rf_wptr_r + 1'b1;
            if (rf_pop)  rf_rptr_r <= rf_rptr_r + 1'b1;
        end
    end

    // storage carries no reset; occupancy is defined entirely by the pointers
    always_ff @(posedge clk) begin
        if (ev_enq)
            evict_q_r[ev_wptr_r[lg_evict_lp-1:0]] <= dma_pkt_i;
        if (rf_push) begin
            rf_data_r[rf_wptr_r[lg_refill_lp-1:0]] <= mem_data_i;
            rf_id_r[rf_wptr_r[lg_refill_lp-1:0]]   <= mem_mshr_id_i;
        end
    end

endmodule

// File: tb/tb_bsg_cache_nb_dma_splitter.sv
// Directed self-checking bench for bsg_cache_nb_dma_splitter at default parameters.
module tb_bsg_cache_nb_dma_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic [42:0] dma_pkt_i;
    logic        dma_pkt_v_i, dma_pkt_yumi_o;
    logic [63:0] dma_data_i;
    logic        dma_data_v_i, dma_data_yumi_o;
    logic [63:0] dma_data_o;
    logic [1:0]  dma_mshr_id_o;
    logic        dma_data_v_o, dma_data_ready_i;
    logic [42:0] rd_pkt_o;
    logic        rd_pkt_v_o, rd_pkt_yumi_i;
    logic [42:0] wr_pkt_o;
    logic        wr_pkt_v_o, wr_pkt_yumi_i;
    logic [63:0] wr_data_o;
    logic        wr_data_v_o, wr_data_yumi_i;
    logic [63:0] mem_data_i;
    logic [1:0]  mem_mshr_id_i;
    logic        mem_data_v_i, mem_data_ready_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bsg_cache_nb_dma_splitter dut (
        .clk(clk), .reset(reset),
        .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
        .dma_data_o(dma_data_o), .dma_mshr_id_o(dma_mshr_id_o), .dma_data_v_o(dma_data_v_o),
        .dma_data_ready_i(dma_data_ready_i),
        .rd_pkt_o(rd_pkt_o), .rd_pkt_v_o(rd_pkt_v_o), .rd_pkt_yumi_i(rd_pkt_yumi_i),
        .wr_pkt_o(wr_pkt_o), .wr_pkt_v_o(wr_pkt_v_o), .wr_pkt_yumi_i(wr_pkt_yumi_i),
        .wr_data_o(wr_data_o), .wr_data_v_o(wr_data_v_o), .wr_data_yumi_i(wr_data_yumi_i),
        .mem_data_i(mem_data_i), .mem_mshr_id_i(mem_mshr_id_i), .mem_data_v_i(mem_data_v_i),
        .mem_data_ready_o(mem_data_ready_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [42:0] mk_pkt(input logic w, input logic [31:0] a, input logic [1:0] id);
        return {w, a, 8'hFF, id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hdr(input logic [42:0] exp_hdr);
        bit got = 1'b0;
        wr_pkt_yumi_i = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (wr_pkt_v_o) begin
                got = 1'b1;
                check("hdr", wr_pkt_o, exp_hdr);
            end
            step();
        end
        wr_pkt_yumi_i = 1'b0;
        if (!got) check("hdr_timeout", 0, 1);
    endtask

    // header, then four beats seed..seed+3; optionally toggles yumi and checks the cache packet stays blocked
    task automatic drain(input logic [42:0] exp_hdr, input logic [63:0] seed, input bit chk_blk, input bit toggle);
        int k = 0;
        logic y;
        wait_hdr(exp_hdr);
        for (int c = 0; c < 20 && k < 4; c++) begin
            y = toggle ? logic'(c % 2) : 1'b1;
            dma_data_v_i   = 1'b1;
            dma_data_i     = seed + 64'(k);
            wr_data_yumi_i = y;
            @(negedge clk);
            check("beat_v", wr_data_v_o, 1);
            check("beat_data", wr_data_o, seed + 64'(k));
            check("beat_yumi", dma_data_yumi_o, y);
            if (chk_blk) check("pkt_blocked", dma_pkt_yumi_o, 0);
            if (y) k++;
            step();
        end
        if (k != 4) check("beat_timeout", 64'(k), 4);
        dma_data_v_i   = 1'b0;
        wr_data_yumi_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        dma_pkt_i = mk_pkt(0, 32'h100, 0); dma_pkt_v_i = 1'b1;
        dma_data_i = '0; dma_data_v_i = 1'b1; dma_data_ready_i = 1'b1;
        rd_pkt_yumi_i = 1'b1; wr_pkt_yumi_i = 1'b1; wr_data_yumi_i = 1'b1;
        mem_data_i = '0; mem_mshr_id_i = '0; mem_data_v_i = 1'b1;

        @(negedge clk);
        check("rst_rd_v", rd_pkt_v_o, 0);
        check("rst_pkt_yumi", dma_pkt_yumi_o, 0);
        check("rst_wr_v", wr_pkt_v_o, 0);
        check("rst_data_yumi", dma_data_yumi_o, 0);
        check("rst_refill_v", dma_data_v_o, 0);
        check("rst_mem_ready", mem_data_ready_o, 0);
        step();
        dma_pkt_v_i = 1'b0; dma_data_v_i = 1'b0; mem_data_v_i = 1'b0;
        rd_pkt_yumi_i = 1'b0; wr_pkt_yumi_i = 1'b0; wr_data_yumi_i = 1'b0;
        dma_data_ready_i = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_mem_ready", mem_data_ready_o, 1);
        check("post_rst_wr_data_v", wr_data_v_o, 0);
        step();

        // read pass-through, with and without same-cycle yumi
        dma_pkt_i = mk_pkt(0, 32'h100, 1); dma_pkt_v_i = 1'b1; rd_pkt_yumi_i = 1'b0;
        @(negedge clk);
        check("rd_v_noyumi", rd_pkt_v_o, 1);
        check("rd_pkt_yumi_held", dma_pkt_yumi_o, 0);
        step();
        rd_pkt_yumi_i = 1'b1;
        @(negedge clk);
        check("rd_v", rd_pkt_v_o, 1);
        check("rd_pkt_yumi", dma_pkt_yumi_o, 1);
        check("rd_pkt", rd_pkt_o, mk_pkt(0, 32'h100, 1));
        step();
        dma_pkt_v_i = 1'b0; rd_pkt_yumi_i = 1'b0;

        // write 0x200 then read 0x200: read waits for the whole evict, beats toggled
        dma_pkt_i = mk_pkt(1, 32'h200, 1); dma_pkt_v_i = 1'b1;
        @(negedge clk);
        check("wr_accept", dma_pkt_yumi_o, 1);
        check("wr_not_rd", rd_pkt_v_o, 0);
        step();
        dma_pkt_i = mk_pkt(0, 32'h200, 2); rd_pkt_yumi_i = 1'b1;
        @(negedge clk);
        check("raw_stall", rd_pkt_v_o, 0);
        step();
        drain(mk_pkt(1, 32'h200, 1), 64'hA0, 1'b1, 1'b1);
        dma_data_v_i = 1'b1;
        @(negedge clk);
        check("raw_release", rd_pkt_v_o, 1);
        check("raw_release_yumi", dma_pkt_yumi_o, 1);
        check("idle_wr_data_v", wr_data_v_o, 0);
        check("idle_data_yumi", dma_data_yumi_o, 0);
        check("idle_wr_pkt_v", wr_pkt_v_o, 0);
        step();
        dma_pkt_v_i = 1'b0; dma_data_v_i = 1'b0; rd_pkt_yumi_i = 1'b0;

        // write 0x200 then read 0x400 (different block)
        dma_pkt_i = mk_pkt(1, 32'h200, 3); dma_pkt_v_i = 1'b1;
        @(negedge clk);
        check("wr2_accept", dma_pkt_yumi_o, 1);
        step();
        dma_pkt_i = mk_pkt(0, 32'h400, 0); rd_pkt_yumi_i = 1'b1;
        @(negedge clk);
`ifdef BSG_CACHE_NB_DMA_SPLITTER_RAW_CHECK_EN
        check("nohaz_bypass", rd_pkt_v_o, 1);
        step();
        dma_pkt_v_i = 1'b0;
        drain(mk_pkt(1, 32'h200, 3), 64'hC0, 1'b0, 1'b0);
`else
        check("nohaz_wait", rd_pkt_v_o, 0);
        step();
        drain(mk_pkt(1, 32'h200, 3), 64'hC0, 1'b1, 1'b0);
        @(negedge clk);
        check("nohaz_release", rd_pkt_v_o, 1);
        step();
`endif
        dma_pkt_v_i = 1'b0; rd_pkt_yumi_i = 1'b0;

        // five writes with headers stalled: fifth refused until first evict retires
        for (int i = 0; i < 4; i++) begin
            dma_pkt_i = mk_pkt(1, 32'h1000 + 32'(i*64), 2'(i)); dma_pkt_v_i = 1'b1;
            @(negedge clk);
            check("fill_accept", dma_pkt_yumi_o, 1);
            step();
        end
        dma_pkt_i = mk_pkt(1, 32'h1100, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_refuse", dma_pkt_yumi_o, 0);
            step();
        end
        drain(mk_pkt(1, 32'h1000, 0), 64'h100, 1'b1, 1'b0);
        @(negedge clk);
        check("fifth_accept", dma_pkt_yumi_o, 1);
        step();
        dma_pkt_v_i = 1'b0;
        for (int i = 1; i < 4; i++)
            drain(mk_pkt(1, 32'h1000 + 32'(i*64), 2'(i)), 64'h200 + 64'(i*16), 1'b0, 1'b0);
        drain(mk_pkt(1, 32'h1100, 0), 64'h300, 1'b0, 1'b0);
        @(negedge clk);
        check("drained_idle", wr_pkt_v_o, 0);
        step();

        // refill: fill 16 with ready low, then drain in order
        dma_data_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_data_i = 64'hB000 + 64'(i); mem_mshr_id_i = 2'(i % 4); mem_data_v_i = 1'b1;
            @(negedge clk);
            check("rf_ready", mem_data_ready_o, 1);
            if (i == 0) check("rf_empty_v", dma_data_v_o, 0);
            if (i == 1) check("rf_latency_v", dma_data_v_o, 1);
            step();
        end
        mem_data_i = 64'hDEAD;
        @(negedge clk);
        check("rf_full_ready", mem_data_ready_o, 0);
        step();
        dma_data_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) mem_data_v_i = 1'b0;
            @(negedge clk);
            check("rf_out_v", dma_data_v_o, 1);
            check("rf_out_data", dma_data_o, 64'hB000 + 64'(i));
            check("rf_out_id", dma_mshr_id_o, 64'(i % 4));
            step();
        end
        @(negedge clk);
        check("rf_drained", dma_data_v_o, 0);
        step();
        dma_data_ready_i = 1'b0;

        // reset mid-burst discards header, counter and buffered beats
        dma_pkt_i = mk_pkt(1, 32'h300, 1); dma_pkt_v_i = 1'b1;
        step();
        dma_pkt_v_i = 1'b0;
        wait_hdr(mk_pkt(1, 32'h300, 1));
        dma_data_v_i = 1'b1; wr_data_yumi_i = 1'b1; dma_data_i = 64'hEE;
        mem_data_v_i = 1'b1; mem_data_i = 64'h77;
        step();
        reset = 1'b1; dma_data_v_i = 1'b0; mem_data_v_i = 1'b0;
        step();
        reset = 1'b0; dma_data_v_i = 1'b1;
        dma_pkt_i = mk_pkt(0, 32'h300, 2); dma_pkt_v_i = 1'b1; rd_pkt_yumi_i = 1'b1;
        @(negedge clk);
        check("mrst_wr_data_v", wr_data_v_o, 0);
        check("mrst_wr_pkt_v", wr_pkt_v_o, 0);
        check("mrst_refill_v", dma_data_v_o, 0);
        check("mrst_rd_v", rd_pkt_v_o, 1);
        step();
        dma_pkt_v_i = 1'b0; dma_data_v_i = 1'b0; rd_pkt_yumi_i = 1'b0; wr_data_yumi_i = 1'b0;
        dma_pkt_i = mk_pkt(1, 32'h340, 2); dma_pkt_v_i = 1'b1;
        step();
        dma_pkt_v_i = 1'b0;
        drain(mk_pkt(1, 32'h340, 2), 64'h400, 1'b0, 1'b0);
        dma_data_v_i = 1'b1;
        @(negedge clk);
        check("mrst_full_burst_idle", wr_data_v_o, 0);
        step();
        dma_data_v_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
